// File: rtl/sub_64_bit_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sub_64_bit_pipe
// Brief    : Two-stage 64-bit subtractor (A - B - Bin) with valid/ready flow
//            control; low half in stage 1, high half in stage 2.
//            Optional macro SUB64_OVF_EN adds the signed-overflow output Ovf_o.
// Revision : 1.0 - initial release
// ============================================================================
module sub_64_bit_pipe (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] A_i,
    input  logic [63:0] B_i,
    input  logic        Bin_i,
    input  logic        In_valid_i,
    output logic        In_ready_o,
    output logic [63:0] Diff_o,
    output logic        Bout_o,
    output logic        Zero_o,
    output logic        Out_valid_o,
    input  logic        Out_ready_i
`ifdef SUB64_OVF_EN
    ,
    output logic        Ovf_o
`endif
);

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_diff_lo_q, s1_diff_lo_d;
    logic        s1_borrow_q, s1_borrow_d;
    logic [31:0] s1_a_hi_q, s1_a_hi_d;
    logic [31:0] s1_b_hi_q, s1_b_hi_d;

    logic        s2_valid_q, s2_valid_d;
    logic [63:0] diff_q, diff_d;
    logic        bout_q, bout_d;
    logic        zero_q, zero_d;
`ifdef SUB64_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    logic        w_s2_load;
    logic        w_in_ready;
    logic        w_in_fire;
    logic [32:0] w_lo_sub;
    logic [32:0] w_hi_sub;

    always_comb begin
        // Stage 2 frees up whenever its current result leaves this cycle.
        w_s2_load  = !s2_valid_q || Out_ready_i;
        w_in_ready = !s1_valid_q || w_s2_load;
        w_in_fire  = In_valid_i && w_in_ready;

        // Bit 32 of each 33-bit difference is the borrow out of that half.
        w_lo_sub = {1'b0, A_i[31:0]} - {1'b0, B_i[31:0]} - {32'b0, Bin_i};
        w_hi_sub = {1'b0, s1_a_hi_q} - {1'b0, s1_b_hi_q} - {32'b0, s1_borrow_q};

        s1_valid_d   = s1_valid_q;
        s1_diff_lo_d = s1_diff_lo_q;
        s1_borrow_d  = s1_borrow_q;
        s1_a_hi_d    = s1_a_hi_q;
        s1_b_hi_d    = s1_b_hi_q;
        if (w_in_fire) begin
            s1_valid_d   = 1'b1;
            s1_diff_lo_d = w_lo_sub[31:0];
            s1_borrow_d  = w_lo_sub[32];
            s1_a_hi_d    = A_i[63:32];
            s1_b_hi_d    = B_i[63:32];
        end else if (w_s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        zero_d     = zero_q;
`ifdef SUB64_OVF_EN
        ovf_d      = ovf_q;
`endif
        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = {w_hi_sub[31:0], s1_diff_lo_q};
                bout_d = w_hi_sub[32];
                zero_d = ({w_hi_sub[31:0], s1_diff_lo_q} == 64'd0);
`ifdef SUB64_OVF_EN
                ovf_d  = (s1_a_hi_q[31] != s1_b_hi_q[31]) &&
                         (w_hi_sub[31] != s1_a_hi_q[31]);
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_diff_lo_q <= 32'd0;
            s1_borrow_q  <= 1'b0;
            s1_a_hi_q    <= 32'd0;
            s1_b_hi_q    <= 32'd0;
            s2_valid_q   <= 1'b0;
            diff_q       <= 64'd0;
            bout_q       <= 1'b0;
            zero_q       <= 1'b0;
`ifdef SUB64_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_lo_q <= s1_diff_lo_d;
            s1_borrow_q  <= s1_borrow_d;
            s1_a_hi_q    <= s1_a_hi_d;
            s1_b_hi_q    <= s1_b_hi_d;
            s2_valid_q   <= s2_valid_d;
            diff_q       <= diff_d;
            bout_q       <= bout_d;
            zero_q       <= zero_d;
`ifdef SUB64_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign In_ready_o  = w_in_ready;
    assign Diff_o      = diff_q;
    assign Bout_o      = bout_q;
    assign Zero_o      = zero_q;
    assign Out_valid_o = s2_valid_q;
`ifdef SUB64_OVF_EN
    assign Ovf_o       = ovf_q;
`endif

endmodule
`default_nettype wire
